// File: rtl/axis_rx_pkt_rr_arb.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream rx lanes onto one
// core-ingress stream, with oversize truncation and per-port packet counters.
module axis_rx_pkt_rr_arb #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16,
  localparam int GW       = $clog2(NUM_PORTS),
  localparam int BW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0]   s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic [KEEP_W-1:0]             m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic [NUM_PORTS-1:0]          port_en,
  input  logic                          cnt_clr,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          trunc_pulse,
  output logic [NUM_PORTS*CNT_W-1:0]    pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [GW-1:0]        grant, grant_nx;
  logic [BW-1:0]        beat_cnt, beat_cnt_nx;
  logic                 trunc_q, trunc_nx;
  logic [CNT_W-1:0]     cnt [NUM_PORTS];

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [NUM_PORTS-1:0] done;
  logic [GW-1:0]        rr_pick;
  logic                 rr_hit;

  logic [DATA_W-1:0]    sel_data;
  logic [KEEP_W-1:0]    sel_keep;
  logic                 sel_last;
  logic                 sel_valid;
  logic                 at_limit;

  logic [NUM_PORTS-1:0] s_ready_c;
  logic [DATA_W-1:0]    m_data_c;
  logic [KEEP_W-1:0]    m_keep_c;
  logic                 m_last_c;
  logic                 m_valid_c;

  assign req      = s_axis_tvalid & port_en;
  assign rr_hit   = |req;
  assign grant_oh = NUM_PORTS'(1) << grant;
  assign at_limit = (beat_cnt == BW'(MAX_BEATS - 1));

  // Granted-port mux.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant == GW'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
        sel_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        sel_last  = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  // Round-robin pick: the requester at the smallest forward distance from the
  // last grant wins (distance NUM_PORTS means the last grantee itself).
  always_comb begin
    int unsigned g;
    int unsigned d;
    int unsigned best;
    g       = 32'(grant);
    best    = NUM_PORTS + 1;
    d       = 0;
    rr_pick = grant;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      d = (i > g) ? (i - g) : (i + NUM_PORTS - g);
      if (req[i] && (d < best)) begin
        best    = d;
        rr_pick = GW'(i);
      end
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    beat_cnt_nx = beat_cnt;
    trunc_nx    = 1'b0;
    done        = '0;
    s_ready_c   = '0;
    m_data_c    = '0;
    m_keep_c    = '0;
    m_last_c    = 1'b0;
    m_valid_c   = 1'b0;
    case (state)
      IDLE: begin
        if (rr_hit) begin
          grant_nx    = rr_pick;
          beat_cnt_nx = '0;
          state_nx    = PASS;
        end
      end
      PASS: begin
        m_data_c  = sel_data;
        m_keep_c  = sel_keep;
        m_valid_c = sel_valid;
        m_last_c  = sel_last | at_limit;
        s_ready_c = grant_oh & {NUM_PORTS{m_axis_tready}};
        if (sel_valid && m_axis_tready) begin
          beat_cnt_nx = beat_cnt + BW'(1);
          if (sel_last) begin
            done     = grant_oh;
            state_nx = IDLE;
          end else if (at_limit) begin
            done     = grant_oh;
            trunc_nx = 1'b1;
            state_nx = DROP;
          end
        end
      end
      DROP: begin
        s_ready_c = grant_oh;
        if (sel_valid && sel_last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= GW'(NUM_PORTS - 1);
      beat_cnt <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      beat_cnt <= beat_cnt_nx;
      trunc_q  <= trunc_nx;
    end
  end

  // Clear wins over a same-cycle completion; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (done[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Outputs are forced to their reset values for the whole time rst is high,
  // including the cycle before the synchronous reset has taken effect.
  assign s_axis_tready = rst ? '0 : s_ready_c;
  assign m_axis_tdata  = rst ? '0 : m_data_c;
  assign m_axis_tkeep  = rst ? '0 : m_keep_c;
  assign m_axis_tlast  = m_last_c & ~rst;
  assign m_axis_tvalid = m_valid_c & ~rst;
  assign grant_id      = rst ? GW'(NUM_PORTS - 1) : grant;
  assign busy          = (state != IDLE) & ~rst;
  assign trunc_pulse   = trunc_q & ~rst;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign pkt_cnt[i*CNT_W +: CNT_W] = rst ? '0 : cnt[i];
  end

endmodule
